gerador_pulso_acao: RTL



---
 rtl/gerador_pulso_acao_pkg.sv | 19 +
 rtl/gerador_pulso_acao_sincronizador_2ff.sv | 38 +++
 rtl/gerador_pulso_acao.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gerador_pulso_acao_pkg.sv
// pkg_sequenciador: definitions shared by the sequencer's input conditioners.
//   - estado_btn_t: debounce FSM state encoding. Bit 1 set means "pressed
//     as far as the outside world knows".
//   - DEBOUNCE_CYCLES_DEF: default debounce window, derived from the board
//     clock frequency and the desired window in milliseconds.
package pkg_sequenciador;

  localparam int CLK_FREQ_HZ         = 50_000_000;
  localparam int DEBOUNCE_MS         = 20;
  localparam int DEBOUNCE_CYCLES_DEF = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic [1:0] {
    SOLTO       = 2'b00,
    CONF_PRESS  = 2'b01,
    PRESSIONADO = 2'b10,
    CONF_SOLTA  = 2'b11
  } estado_btn_t;

endpackage

// File: rtl/gerador_pulso_acao_sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchronizer for one asynchronous level.
// Ports:
//   clk      - destination clock
//   rst_n    - asynchronous active-low reset; both flops load RST_VAL
//   d_async  - asynchronous input level
//   d_sync   - synchronized level, two clk edges behind d_async
// RST_VAL should be the input's idle level so that releasing reset does not
// fabricate an edge.
module sincronizador_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic d_sync
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d_async;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign d_sync = sync_q;

endmodule

// File: rtl/gerador_pulso_acao.sv
// gerador_pulso_acao: turns a raw bouncing push-button into exactly one
// single-cycle action_pulso per confirmed press.
// Ports:
//   clk           - system clock
//   rst_n         - asynchronous active-low reset
//   botao_raw     - raw button level (polarity set by BTN_ACTIVE_LOW)
//   habilita      - 1 allows pulse generation; 0 tracks presses silently
//   action_pulso  - one-cycle registered pulse per confirmed press
//   botao_estavel - debounced pressed level (1 = pressed)
//
// state       | meaning
// ------------+---------------------------------------------------
// SOLTO       | released and stable
// CONF_PRESS  | press seen, counting stable cycles to confirm it
// PRESSIONADO | press confirmed and stable
// CONF_SOLTA  | release seen, counting stable cycles to confirm it
module gerador_pulso_acao
  import pkg_sequenciador::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic botao_raw,
  input  logic habilita,
  output logic action_pulso,
  output logic botao_estavel
);

  localparam logic             RAW_IDLE = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic btn_sync;
  logic btn_s;

  sincronizador_2ff #(
    .RST_VAL (RAW_IDLE)
  ) u_sinc_botao (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (botao_raw),
    .d_sync  (btn_sync)
  );

  assign btn_s = BTN_ACTIVE_LOW ? ~btn_sync : btn_sync;

  estado_btn_t      estado_d, estado_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             pulso_d, pulso_q;
  logic             cnt_fim;

  assign cnt_fim = (cnt_q == CNT_MAX);

  // The counter is cleared on every transition so each CONF_* state starts
  // from zero and it can never wrap.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    pulso_d  = 1'b0;
    case (estado_q)
      SOLTO: begin
        if (btn_s) begin
          estado_d = CONF_PRESS;
          cnt_d    = '0;
        end
      end
      CONF_PRESS: begin
        if (!btn_s) begin
          estado_d = SOLTO;
          cnt_d    = '0;
        end else if (cnt_fim) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
          // A disabled confirm drops the pulse for good; nothing is queued.
          pulso_d  = habilita;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSIONADO: begin
        if (!btn_s) begin
          estado_d = CONF_SOLTA;
          cnt_d    = '0;
        end
      end
      CONF_SOLTA: begin
        if (btn_s) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
        end else if (cnt_fim) begin
          estado_d = SOLTO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        estado_d = SOLTO;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= SOLTO;
      cnt_q    <= '0;
      pulso_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      pulso_q  <= pulso_d;
    end
  end

  assign action_pulso = pulso_q;
  // PRESSIONADO and CONF_SOLTA share bit 1, so the pressed level comes
  // straight off one state flop and cannot glitch.
  assign botao_estavel = estado_q[1];

endmodule
